// File: rtl/mul_pkg.sv
// Shared constants and helpers for the pipelined Vedic multiplier family.
package mul_pkg;

    localparam int WIDTH_MIN = 4;
    localparam int WIDTH_MAX = 64;

    function automatic int MUL_LAT(input int width);
        return $clog2(width);
    endfunction

    function automatic bit is_pow2(input int v);
        return (v > 0) && ((v & (v - 1)) == 0);
    endfunction

    // 2x2 leaf cell: the only true multiplication in the tree
    function automatic logic [3:0] mul2x2(input logic [1:0] a, input logic [1:0] b);
        return {2'b00, a} * {2'b00, b};
    endfunction

endpackage

// File: rtl/vedic_combine.sv
// Urdhva-Tiryagbhyam quadrant combiner: four 2N-bit partial products -> one 4N-bit product.
module vedic_combine #(
    parameter int N = 2
) (
    input  logic [2*N-1:0] i_hh,
    input  logic [2*N-1:0] i_hl,
    input  logic [2*N-1:0] i_lh,
    input  logic [2*N-1:0] i_ll,
    output logic [4*N-1:0] o_p
);

    logic [2*N:0] w_mid;

    assign w_mid = {1'b0, i_hl} + {1'b0, i_lh};
    assign o_p   = {i_hh, {(2*N){1'b0}}}
                 + {{(N-1){1'b0}}, w_mid, {N{1'b0}}}
                 + {{(2*N){1'b0}}, i_ll};

endmodule

// File: rtl/vedic_mul_pipe.sv
// Pipelined WIDTH x WIDTH Vedic multiplier: one register stage per recursion level,
// lock-step stall, signed operands handled by magnitude plus a carried sign.
module vedic_mul_pipe
    import mul_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int TAG_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    input  logic               in_signed,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out_p,
    output logic [TAG_W-1:0]   out_tag
);

    localparam int L = MUL_LAT(WIDTH);

    if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX || !is_pow2(WIDTH) || TAG_W < 1) begin : g_param_check
        $error("vedic_mul_pipe: WIDTH must be a power of two in [%0d,%0d], TAG_W >= 1",
               WIDTH_MIN, WIDTH_MAX);
    end

    logic               w_stall;
    logic [WIDTH-1:0]   w_mag_a;
    logic [WIDTH-1:0]   w_mag_b;
    logic               w_neg_in;

    logic [L:1]         r_vld;
    logic [L-1:1]       r_neg;
    logic [TAG_W-1:0]   r_tag [1:L];

    // The whole pipe moves as one shift register; a held output freezes every stage.
    assign w_stall  = r_vld[L] && !out_ready;
    assign in_ready = !w_stall;

    // |-2^(W-1)| wraps to 2^(W-1), which is still correct as an unsigned magnitude.
    assign w_mag_a  = (in_signed && in_a[WIDTH-1]) ? -in_a : in_a;
    assign w_mag_b  = (in_signed && in_b[WIDTH-1]) ? -in_b : in_b;
    assign w_neg_in = in_signed && (in_a[WIDTH-1] ^ in_b[WIDTH-1]);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld    <= '0;
            r_tag[L] <= '0;
        end else if (!w_stall) begin
            r_vld[1] <= in_valid;
            r_neg[1] <= w_neg_in;
            r_tag[1] <= in_tag;
            for (int s = 2; s <= L; s++) begin
                r_vld[s] <= r_vld[s-1];
                r_tag[s] <= r_tag[s-1];
            end
            for (int s = 2; s <= L - 1; s++) begin
                r_neg[s] <= r_neg[s-1];
            end
        end
    end

    // Level k holds (WIDTH>>k)^2 products of (2<<k) bits, indexed [a_digit*D + b_digit].
    for (genvar k = 1; k <= L; k++) begin : g_lvl
        localparam int D  = WIDTH >> k;
        localparam int PW = 2 << k;

        logic [PW-1:0] w_prod [D*D];
        logic [PW-1:0] r_prod [D*D];

        if (k == 1) begin : g_leaf
            // stage 1: 2x2 leaf products
            for (genvar I = 0; I < D; I++) begin : g_row
                for (genvar J = 0; J < D; J++) begin : g_col
                    assign w_prod[I*D+J] = mul2x2(w_mag_a[2*I +: 2], w_mag_b[2*J +: 2]);
                end
            end
        end else begin : g_comb
            // stage k: quadrant combine; the last stage also applies the sign
            for (genvar I = 0; I < D; I++) begin : g_row
                for (genvar J = 0; J < D; J++) begin : g_col
                    logic [PW-1:0] w_sum;

                    vedic_combine #(.N(PW/4)) u_comb (
                        .i_hh (g_lvl[k-1].r_prod[(2*I+1)*(2*D) + 2*J+1]),
                        .i_hl (g_lvl[k-1].r_prod[(2*I+1)*(2*D) + 2*J]),
                        .i_lh (g_lvl[k-1].r_prod[(2*I)*(2*D) + 2*J+1]),
                        .i_ll (g_lvl[k-1].r_prod[(2*I)*(2*D) + 2*J]),
                        .o_p  (w_sum)
                    );

                    assign w_prod[I*D+J] = (k == L && r_neg[L-1]) ? -w_sum : w_sum;
                end
            end
        end

        if (k == L) begin : g_out
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_prod[0] <= '0;
                end else if (!w_stall) begin
                    r_prod[0] <= w_prod[0];
                end
            end
        end else begin : g_mid
            always_ff @(posedge clk) begin
                if (!w_stall) begin
                    r_prod <= w_prod;
                end
            end
        end
    end

    assign out_valid = r_vld[L];
    assign out_tag   = r_tag[L];
    assign out_p     = g_lvl[L].r_prod[0];

endmodule

// File: tb/tb_vedic_mul_pipe.sv
// Directed and streaming checks for vedic_mul_pipe at WIDTH 16, plus a 4/8/32/64 sweep.
module tb_vedic_mul_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_a = '0;
    logic [15:0] in_b = '0;
    logic        in_signed = 1'b0;
    logic [3:0]  in_tag = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_p;
    logic [3:0]  out_tag;

    logic        s_valid [4];
    logic        s_iready [4];
    logic        s_sgn [4];
    logic [3:0]  s_tag [4];
    logic        s_ovalid [4];
    logic [3:0]  s_otag [4];
    logic [127:0] s_p [4];
    logic [3:0]   a_w4,  b_w4;
    logic [7:0]   a_w8,  b_w8;
    logic [31:0]  a_w32, b_w32;
    logic [63:0]  a_w64, b_w64;
    logic [7:0]   p_w4;
    logic [15:0]  p_w8;
    logic [63:0]  p_w32;
    logic [127:0] p_w64;

    int cyc = 0;
    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    vedic_mul_pipe #(.WIDTH(16), .TAG_W(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_signed(in_signed), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_p(out_p), .out_tag(out_tag)
    );

    vedic_mul_pipe #(.WIDTH(4), .TAG_W(4)) u_w4 (
        .clk(clk), .rst(rst), .in_valid(s_valid[0]), .in_ready(s_iready[0]),
        .in_a(a_w4), .in_b(b_w4), .in_signed(s_sgn[0]), .in_tag(s_tag[0]),
        .out_valid(s_ovalid[0]), .out_ready(1'b1), .out_p(p_w4), .out_tag(s_otag[0])
    );
    vedic_mul_pipe #(.WIDTH(8), .TAG_W(4)) u_w8 (
        .clk(clk), .rst(rst), .in_valid(s_valid[1]), .in_ready(s_iready[1]),
        .in_a(a_w8), .in_b(b_w8), .in_signed(s_sgn[1]), .in_tag(s_tag[1]),
        .out_valid(s_ovalid[1]), .out_ready(1'b1), .out_p(p_w8), .out_tag(s_otag[1])
    );
    vedic_mul_pipe #(.WIDTH(32), .TAG_W(4)) u_w32 (
        .clk(clk), .rst(rst), .in_valid(s_valid[2]), .in_ready(s_iready[2]),
        .in_a(a_w32), .in_b(b_w32), .in_signed(s_sgn[2]), .in_tag(s_tag[2]),
        .out_valid(s_ovalid[2]), .out_ready(1'b1), .out_p(p_w32), .out_tag(s_otag[2])
    );
    vedic_mul_pipe #(.WIDTH(64), .TAG_W(4)) u_w64 (
        .clk(clk), .rst(rst), .in_valid(s_valid[3]), .in_ready(s_iready[3]),
        .in_a(a_w64), .in_b(b_w64), .in_signed(s_sgn[3]), .in_tag(s_tag[3]),
        .out_valid(s_ovalid[3]), .out_ready(1'b1), .out_p(p_w64), .out_tag(s_otag[3])
    );

    assign s_p[0] = {120'd0, p_w4};
    assign s_p[1] = {112'd0, p_w8};
    assign s_p[2] = {64'd0, p_w32};
    assign s_p[3] = p_w64;

    // Reference: sign-extend into 128 bits, multiply, keep the low 2*w bits.
    function automatic logic [127:0] ref_mul(input logic [63:0] a, input logic [63:0] b,
                                             input logic s, input int w);
        logic [127:0] xa, xb, m;
        m  = (128'd1 << w) - 128'd1;
        xa = {64'd0, a} & m;
        xb = {64'd0, b} & m;
        if (s && xa[w-1]) xa = xa - (128'd1 << w);
        if (s && xb[w-1]) xb = xb - (128'd1 << w);
        return (xa * xb) & ((128'd1 << (2*w)) - 128'd1);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sw_ab(input int i, input logic [63:0] a, input logic [63:0] b);
        case (i)
            0:       begin a_w4  = a[3:0];  b_w4  = b[3:0];  end
            1:       begin a_w8  = a[7:0];  b_w8  = b[7:0];  end
            2:       begin a_w32 = a[31:0]; b_w32 = b[31:0]; end
            default: begin a_w64 = a;       b_w64 = b;       end
        endcase
    endtask

    // Waits (bounded) for out_valid of the main DUT (i<0) or sweep instance i; returns cycle stamp.
    task automatic wait_out(input int i, output int stamp);
        stamp = -1000;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (((i < 0) ? out_valid : s_ovalid[i]) === 1'b1) begin
                stamp = cyc;
                return;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        @(negedge clk);
        n_vec++;
        if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        n_vec++;
        if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        n_vec++;
        if (out_p !== 32'h0) begin n_err++; $display("FAIL reset_out_p got %h want 0", out_p); end
        n_vec++;
        if (out_tag !== 4'h0) begin n_err++; $display("FAIL reset_out_tag got %h want 0", out_tag); end
        for (int i = 0; i < 4; i++) begin
            n_vec++;
            if (s_ovalid[i] !== 1'b0) begin n_err++; $display("FAIL reset_sweep%0d_valid got %b want 0", i, s_ovalid[i]); end
        end
        tick();
        rst = 1'b0;
        @(negedge clk);
        n_vec++;
        if (in_ready !== 1'b1) begin n_err++; $display("FAIL post_reset_in_ready got %b want 1", in_ready); end
        tick();
    endtask

    task automatic test_directed();
        logic [15:0] va [5];
        logic [15:0] vb [5];
        logic        vs [5];
        logic [31:0] vp [5];
        int t0, t1;
        va[0] = 16'hFFFF; vb[0] = 16'hFFFF; vs[0] = 1'b0; vp[0] = 32'hFFFE0001;
        va[1] = 16'h8000; vb[1] = 16'h8000; vs[1] = 1'b1; vp[1] = 32'h40000000;
        va[2] = 16'h8000; vb[2] = 16'h0001; vs[2] = 1'b1; vp[2] = 32'hFFFF8000;
        va[3] = 16'hFFFF; vb[3] = 16'h0003; vs[3] = 1'b1; vp[3] = 32'hFFFFFFFD;
        va[4] = 16'hFFFF; vb[4] = 16'h0003; vs[4] = 1'b0; vp[4] = 32'h0002FFFD;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_a = va[i]; in_b = vb[i]; in_signed = vs[i]; in_tag = 4'(i + 5);
            @(negedge clk);
            t0 = cyc;
            tick();
            in_valid = 1'b0;
            wait_out(-1, t1);
            n_vec++;
            if (t1 - t0 !== 4) begin n_err++; $display("FAIL dir%0d_latency got %0d want 4", i, t1 - t0); end
            n_vec++;
            if (out_p !== vp[i]) begin n_err++; $display("FAIL dir%0d_product got %h want %h", i, out_p, vp[i]); end
            n_vec++;
            if (out_tag !== 4'(i + 5)) begin n_err++; $display("FAIL dir%0d_tag got %h want %h", i, out_tag, 4'(i + 5)); end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0]  ta [100];
        logic [15:0]  tb_ [100];
        logic         ts [100];
        logic [31:0]  q_p [$];
        logic [3:0]   q_t [$];
        logic [127:0] pe;
        int idx = 0, res = 0, first_c = 0, last_c = 0;
        for (int i = 0; i < 100; i++) begin
            ta[i] = 16'($urandom); tb_[i] = 16'($urandom); ts[i] = 1'($urandom_range(0, 1));
        end
        ta[0] = 16'h8000; tb_[0] = 16'h7FFF; ts[0] = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < 200 && res < 100; c++) begin
            if (idx < 100) begin
                in_valid = 1'b1; in_a = ta[idx]; in_b = tb_[idx]; in_signed = ts[idx]; in_tag = idx[3:0];
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            if (in_valid && in_ready) begin
                pe = ref_mul({48'd0, ta[idx]}, {48'd0, tb_[idx]}, ts[idx], 16);
                q_p.push_back(pe[31:0]);
                q_t.push_back(idx[3:0]);
                idx++;
            end
            if (out_valid && out_ready) begin
                n_vec++;
                if (q_p.size() == 0) begin
                    n_err++; $display("FAIL b2b_extra got %h want none", out_p);
                end else begin
                    if (out_p !== q_p[0] || out_tag !== q_t[0]) begin
                        n_err++; $display("FAIL b2b_result%0d got %h/%h want %h/%h", res, out_p, out_tag, q_p[0], q_t[0]);
                    end
                    void'(q_p.pop_front());
                    void'(q_t.pop_front());
                end
                if (res == 0) first_c = cyc;
                last_c = cyc;
                res++;
            end
            tick();
        end
        in_valid = 1'b0;
        n_vec++;
        if (res !== 100) begin n_err++; $display("FAIL b2b_count got %0d want 100", res); end
        n_vec++;
        if (last_c - first_c !== 99) begin n_err++; $display("FAIL b2b_rate got %0d cycles want 99", last_c - first_c); end
    endtask

    task automatic test_backpressure();
        logic [31:0] q_p [$];
        logic [3:0]  q_t [$];
        int idx = 0, res = 0, stalls = 0, extra = 0;
        out_ready = 1'b0;
        for (int c = 0; c < 80 && res < 8; c++) begin
            in_valid = (idx < 8); in_a = 16'(idx + 3); in_b = 16'(idx + 5);
            in_signed = 1'b0; in_tag = 4'(idx + 1);
            @(negedge clk);
            if (out_valid && !out_ready) begin
                n_vec++;
                if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_in_ready got %b want 0", in_ready); end
                n_vec++;
                if (q_p.size() == 0 || out_p !== q_p[0] || out_tag !== q_t[0]) begin
                    n_err++; $display("FAIL bp_hold got %h/%h want %h/%h", out_p, out_tag,
                                      (q_p.size() > 0) ? q_p[0] : 32'h0, (q_t.size() > 0) ? q_t[0] : 4'h0);
                end
                stalls++;
            end
            if (in_valid && in_ready) begin
                q_p.push_back(32'((idx + 3) * (idx + 5)));
                q_t.push_back(4'(idx + 1));
                idx++;
            end
            if (out_valid && out_ready) begin
                n_vec++;
                if (q_p.size() == 0) begin
                    n_err++; $display("FAIL bp_extra got %h want none", out_p);
                end else begin
                    if (out_p !== q_p[0] || out_tag !== q_t[0]) begin
                        n_err++; $display("FAIL bp_result%0d got %h/%h want %h/%h", res, out_p, out_tag, q_p[0], q_t[0]);
                    end
                    void'(q_p.pop_front());
                    void'(q_t.pop_front());
                end
                res++;
            end
            tick();
            out_ready = (stalls >= 5);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        n_vec++;
        if (res !== 8 || stalls !== 5) begin n_err++; $display("FAIL bp_count got %0d results %0d stalls want 8 and 5", res, stalls); end
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (out_valid !== 1'b0) extra++;
            tick();
        end
        n_vec++;
        if (extra !== 0) begin n_err++; $display("FAIL bp_duplicate got %0d want 0", extra); end
    endtask

    task automatic test_reset_flight();
        int seen = 0, t0, t1;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_a = 16'(16'h0100 + i); in_b = 16'h0002; in_signed = 1'b0; in_tag = 4'(10 + i);
            tick();
        end
        in_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        n_vec++;
        if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_flush_valid got %b want 0", out_valid); end
        tick();
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (out_valid !== 1'b0) seen++;
            tick();
        end
        n_vec++;
        if (seen !== 0) begin n_err++; $display("FAIL rst_ghost_results got %0d want 0", seen); end
        in_valid = 1'b1; in_a = 16'h1234; in_b = 16'h0010; in_signed = 1'b0; in_tag = 4'hD;
        @(negedge clk);
        t0 = cyc;
        tick();
        in_valid = 1'b0;
        wait_out(-1, t1);
        n_vec++;
        if (t1 - t0 !== 4) begin n_err++; $display("FAIL rst_new_latency got %0d want 4", t1 - t0); end
        n_vec++;
        if (out_p !== 32'h00012340 || out_tag !== 4'hD) begin
            n_err++; $display("FAIL rst_new_result got %h/%h want 00012340/d", out_p, out_tag);
        end
        tick();
    endtask

    task automatic test_sweep();
        int           ws [4];
        int           lat [4];
        logic [63:0]  da [4];
        logic [63:0]  db [4];
        logic         ds [4];
        logic [127:0] dp [4];
        logic [127:0] q_p [$];
        logic [3:0]   q_t [$];
        logic [63:0]  ca, cb, mask;
        logic         cs;
        int t0, t1, nv, k, res;
        ws[0] = 4;  lat[0] = 2; da[0] = 64'h8; db[0] = 64'h8; ds[0] = 1'b1; dp[0] = 128'h40;
        ws[1] = 8;  lat[1] = 3; da[1] = 64'h80; db[1] = 64'h80; ds[1] = 1'b1; dp[1] = 128'h4000;
        ws[2] = 32; lat[2] = 5; da[2] = 64'hFFFFFFFF; db[2] = 64'hFFFFFFFF; ds[2] = 1'b0;
        dp[2] = 128'hFFFFFFFE00000001;
        ws[3] = 64; lat[3] = 6; da[3] = '1; db[3] = '1; ds[3] = 1'b0;
        dp[3] = 128'hFFFFFFFFFFFFFFFE0000000000000001;
        for (int i = 0; i < 4; i++) begin
            mask = (ws[i] == 64) ? '1 : ((64'd1 << ws[i]) - 64'd1);
            s_valid[i] = 1'b1; sw_ab(i, da[i], db[i]); s_sgn[i] = ds[i]; s_tag[i] = 4'h9;
            @(negedge clk);
            t0 = cyc;
            tick();
            s_valid[i] = 1'b0;
            wait_out(i, t1);
            n_vec++;
            if (t1 - t0 !== lat[i]) begin n_err++; $display("FAIL w%0d_latency got %0d want %0d", ws[i], t1 - t0, lat[i]); end
            n_vec++;
            if (s_p[i] !== dp[i] || s_otag[i] !== 4'h9) begin
                n_err++; $display("FAIL w%0d_directed got %h/%h want %h/9", ws[i], s_p[i], s_otag[i], dp[i]);
            end
            tick();
            nv = (ws[i] == 4) ? 512 : 40;
            k = 0; res = 0;
            ca = '0; cb = '0; cs = 1'b0;
            for (int c = 0; c < nv + 40 && res < nv; c++) begin
                if (ws[i] == 4) begin
                    ca = 64'(k[3:0]); cb = 64'(k[7:4]); cs = k[8];
                end else begin
                    ca = {$urandom(), $urandom()} & mask;
                    cb = {$urandom(), $urandom()} & mask;
                    cs = 1'($urandom_range(0, 1));
                end
                s_valid[i] = (k < nv); sw_ab(i, ca, cb); s_sgn[i] = cs; s_tag[i] = k[3:0];
                @(negedge clk);
                if (s_valid[i] && s_iready[i]) begin
                    q_p.push_back(ref_mul(ca, cb, cs, ws[i]));
                    q_t.push_back(k[3:0]);
                    k++;
                end
                if (s_ovalid[i] === 1'b1) begin
                    n_vec++;
                    if (q_p.size() == 0) begin
                        n_err++; $display("FAIL w%0d_extra got %h want none", ws[i], s_p[i]);
                    end else begin
                        if (s_p[i] !== q_p[0] || s_otag[i] !== q_t[0]) begin
                            n_err++; $display("FAIL w%0d_stream%0d got %h/%h want %h/%h", ws[i], res, s_p[i], s_otag[i], q_p[0], q_t[0]);
                        end
                        void'(q_p.pop_front());
                        void'(q_t.pop_front());
                    end
                    res++;
                end
                tick();
            end
            s_valid[i] = 1'b0;
            n_vec++;
            if (res !== nv) begin n_err++; $display("FAIL w%0d_count got %0d want %0d", ws[i], res, nv); end
            q_p.delete();
            q_t.delete();
        end
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            s_valid[i] = 1'b0; s_sgn[i] = 1'b0; s_tag[i] = '0;
            sw_ab(i, 64'd0, 64'd0);
        end
        test_reset();
        test_directed();
        test_back_to_back();
        test_backpressure();
        test_reset_flight();
        test_sweep();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
